ifu_fetch: RTL

- Instruction-fetch unit; the consumer end of the PC interface.
- Takes the current fetch address from the pc register and returns the static next address (pc+4) to it.
- Holds the pc via a stall signal until the fetch completes, then issues one request at a time to instruction memory.
- Buffers the returned instruction in a single-entry register toward ID, and discards in-flight fetches on redirect (ID/EX branch).

---
 rtl/ifu_fetch_pkg.sv | 16 +
 rtl/ifu_out_buf.sv | 62 ++++++
 rtl/ifu_fetch.sv | 98 +++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: bus widths, NOP encoding,
// reset level and FSM state encodings. Optional check: YSYX22040228_IFU_MISALIGN_CHK_EN.
package ifu_fetch_pkg;

  localparam int unsigned PC_W      = 64;
  localparam int unsigned INST_W    = 32;
  localparam logic [31:0] NOP_ENC   = 32'h0000_0013;
  localparam logic        RST_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_out_buf.sv
// Single-entry valid/ready holding register toward ID. A flush clears the entry
// and takes priority over a same-cycle load.
module ifu_out_buf
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_W,
  parameter int unsigned INST_WIDTH = INST_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic [INST_WIDTH-1:0] i_inst,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_excp,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic                  o_excp,
  output logic                  o_can_issue
);

  logic                  r_valid;
  logic [INST_WIDTH-1:0] r_inst;
  logic [PC_WIDTH-1:0]   r_pc;
  logic                  r_excp;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is reset too: ID must see all-zero fields coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst <= '0;
      r_pc   <= '0;
      r_excp <= 1'b0;
    end else if (i_load && !i_flush) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
      r_excp <= i_excp;
    end
  end

  assign o_valid     = r_valid;
  assign o_inst      = r_inst;
  assign o_pc        = r_pc;
  assign o_excp      = r_excp;
  assign o_can_issue = ~r_valid | i_ready;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: one outstanding imem request, pc held until capture,
// in-flight fetches dropped on redirect. Optional: YSYX22040228_IFU_MISALIGN_CHK_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned           PC_WIDTH   = PC_W,
  parameter int unsigned           INST_WIDTH = INST_W,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = NOP_ENC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic [PC_WIDTH-1:0]   static_pc_o,
  output logic                  pc_stall_o,
  input  logic                  flush_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [INST_WIDTH-1:0] id_inst_o,
  output logic [PC_WIDTH-1:0]   id_pc_o,
  output logic                  id_excp_o
);

  fetch_state_e          r_state;
  logic                  w_rst_act;
  logic                  w_can_issue;
  logic                  w_misalign;
  logic                  w_go;
  logic                  w_excp_load;
  logic                  w_handshake;
  logic                  w_capture;
  logic                  w_load;
  logic [INST_WIDTH-1:0] w_load_inst;

  assign w_rst_act = (rst == RST_LEVEL);

`ifdef YSYX22040228_IFU_MISALIGN_CHK_EN
  assign w_misalign = (pc_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Outputs are gated by reset so nothing is requested while rst is held.
  assign w_go             = (r_state == ST_REQ) & ~w_rst_act & w_can_issue & ~flush_i;
  assign w_excp_load      = w_go & w_misalign;
  assign imem_req_valid_o = w_go & ~w_misalign;
  assign imem_addr_o      = pc_i;
  assign w_handshake      = imem_req_valid_o & imem_req_ready_i;

  assign w_capture   = (r_state == ST_WAIT) & imem_rsp_valid_i & ~flush_i & ~w_rst_act;
  assign w_load      = w_capture | w_excp_load;
  assign w_load_inst = w_excp_load ? NOP_INST : imem_rsp_data_i;

  assign pc_stall_o  = ~w_load;
  assign static_pc_o = pc_i + PC_WIDTH'(4);

  // DROP leaves on any response even under flush: that response retires the
  // only outstanding request, so waiting longer could never end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_REQ;
    end else begin
      case (r_state)
        ST_REQ:  if (w_handshake) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rsp_valid_i)  r_state <= ST_REQ;
          else if (flush_i)      r_state <= ST_DROP;
        end
        ST_DROP: if (imem_rsp_valid_i) r_state <= ST_REQ;
        default: r_state <= ST_REQ;
      endcase
    end
  end

  ifu_out_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_flush     (flush_i),
    .i_inst      (w_load_inst),
    .i_pc        (pc_i),
    .i_excp      (w_excp_load),
    .i_ready     (id_ready_i),
    .o_valid     (id_valid_o),
    .o_inst      (id_inst_o),
    .o_pc        (id_pc_o),
    .o_excp      (id_excp_o),
    .o_can_issue (w_can_issue)
  );

endmodule
